// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one byte-level UART transmitter between NUM_REQ packet
// sources. Grants rotate round-robin at packet boundaries, the grant is held
// until the last byte has been sent, and an idle gap follows every packet.
// Optional macro UART_TX_SCHED_PRIO0_EN: requester 0 wins every arbitration
// it takes part in; the remaining requesters stay round-robin.
module uart_tx_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned GNT_W       = 2,
  parameter int unsigned GAP_CYCLES  = 868,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                 clk_50M,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [GNT_W-1:0]     grant_id,
  output logic                 active,
  output logic                 err
);

  localparam int unsigned ACK_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GAP_W    = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int unsigned ACK_TERM = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;
  localparam int unsigned GAP_TERM = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [GNT_W-1:0]   last_gnt;
  logic [GNT_W-1:0]   pick;
  logic               found;
  int unsigned        rr_j;
  logic               lock;
  logic               last_byte;
  logic [ACK_W-1:0]   ack_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               ack_expired;
  logic               gap_done;

  assign ack_expired = (ack_cnt == ACK_W'(ACK_TERM));
  assign gap_done    = (gap_cnt == GAP_W'(GAP_TERM));

  // Arbitration: first valid requester after last_gnt, wrapping around.
  always_comb begin
    pick  = last_gnt;
    found = 1'b0;
    rr_j  = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      rr_j = (32'(last_gnt) + i) % NUM_REQ;
      if (!found && req_valid[rr_j[GNT_W-1:0]]) begin
        found = 1'b1;
        pick  = rr_j[GNT_W-1:0];
      end
    end
`ifdef UART_TX_SCHED_PRIO0_EN
    if (req_valid[0]) pick = '0;
`endif
  end

  // State register.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic and the combinational handshake/pulse outputs.
  always_comb begin
    state_n   = state;
    req_ready = '0;
    tx_start  = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) state_n = LOAD;
      end
      LOAD: begin
        req_ready[grant_id] = 1'b1;
        if (req_valid[grant_id]) state_n = START;
        else if (!lock)          state_n = IDLE;
      end
      START: begin
        tx_start = 1'b1;
        state_n  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end else if (ack_expired) begin
          err     = 1'b1;
          state_n = GAP;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_n = last_byte ? GAP : LOAD;
      end
      GAP: begin
        if (gap_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant, byte latch, packet lock and the two saturating counters.
  // Both counters are held at zero outside their own state, which clears
  // them on entry without a separate entry strobe.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      grant_id  <= '0;
      active    <= 1'b0;
      tx_data   <= '0;
      last_byte <= 1'b0;
      lock      <= 1'b0;
      last_gnt  <= GNT_W'(NUM_REQ - 1);
      ack_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      if (state != WAIT_ACK)  ack_cnt <= '0;
      else if (!ack_expired)  ack_cnt <= ack_cnt + 1'b1;

      if (state != GAP)       gap_cnt <= '0;
      else if (!gap_done)     gap_cnt <= gap_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id <= pick;
            active   <= 1'b1;
          end
        end
        LOAD: begin
          if (req_valid[grant_id]) begin
            tx_data   <= req_data[8*grant_id +: 8];
            last_byte <= req_last[grant_id];
            lock      <= 1'b1;
          end else if (!lock) begin
            active <= 1'b0;
          end
        end
        WAIT_ACK: begin
          if (!tx_busy && ack_expired) begin
            lock     <= 1'b0;
            last_gnt <= grant_id;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy && last_byte) begin
            lock     <= 1'b0;
            last_gnt <= grant_id;
          end
        end
        GAP: begin
          if (gap_done) active <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: reset, single byte, round-robin order,
// packet lock, mid-packet stall, ack timeout, two-requester arbitration
// (priority variant under UART_TX_SCHED_PRIO0_EN) and reset mid-packet.
`timescale 1ns/1ps
module tb_uart_tx_sched;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err;

  uart_tx_sched #(
    .NUM_REQ(4),
    .GNT_W(2),
    .GAP_CYCLES(868),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk_50M(clk_50M),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .active(active),
    .err(err)
  );

  always #10 clk_50M = ~clk_50M;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy_len = 40;
  bit busy_en = 1'b1;
  int busy_cnt = 0;

  int         st_cyc[$];
  logic [1:0] st_gnt[$];
  logic [7:0] st_data[$];
  int         err_cyc[$];

  // Cycle counter.
  always @(posedge clk_50M) cyc <= cyc + 1;

  // Transmitter model: busy rises one cycle after tx_start, stays busy_len cycles.
  always @(posedge clk_50M) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_start && busy_en) begin
      tx_busy  <= 1'b1;
      busy_cnt <= busy_len - 1;
    end else if (tx_busy) begin
      if (busy_cnt == 0) tx_busy <= 1'b0;
      else               busy_cnt <= busy_cnt - 1;
    end
  end

  // Event log of tx_start pulses and err pulses.
  always @(negedge clk_50M) begin
    if (tx_start === 1'b1) begin
      st_cyc.push_back(cyc);
      st_gnt.push_back(grant_id);
      st_data.push_back(tx_data);
    end
    if (err === 1'b1) err_cyc.push_back(cyc);
  end

  initial begin
    #1_600_000;
    $display("FAIL watchdog: time limit reached, required bench to finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk_50M);
    #1;
  endtask

  task automatic set_req(input int r, input logic [7:0] d, input logic l, input logic v);
    req_data[8*r +: 8] = d;
    req_last[r]        = l;
    req_valid[r]       = v;
  endtask

  task automatic clear_log();
    st_cyc.delete();
    st_gnt.delete();
    st_data.delete();
    err_cyc.delete();
  endtask

  task automatic wait_starts(input int n, input int bound, output bit ok);
    int k = 0;
    while (st_cyc.size() < n && k < bound) begin
      tick();
      k++;
    end
    ok = (st_cyc.size() >= n);
  endtask

  task automatic wait_inactive(input int bound, output int c, output bit ok);
    int k = 0;
    while (active !== 1'b0 && k < bound) begin
      tick();
      k++;
    end
    ok = (active === 1'b0);
    c  = cyc;
  endtask

  task automatic wait_ready(input int r, input int bound, output bit ok);
    int k = 0;
    while (req_ready[r] !== 1'b1 && k < bound) begin
      tick();
      k++;
    end
    ok = (req_ready[r] === 1'b1);
  endtask

  function automatic int gcyc(input int i);
    if (i < st_cyc.size()) return st_cyc[i];
    return -1;
  endfunction

  function automatic logic [1:0] ggnt(input int i);
    if (i < st_gnt.size()) return st_gnt[i];
    return 2'bxx;
  endfunction

  function automatic logic [7:0] gdat(input int i);
    if (i < st_data.size()) return st_data[i];
    return 8'hxx;
  endfunction

  function automatic int gerr(input int i);
    if (i < err_cyc.size()) return err_cyc[i];
    return -1;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) tick();
    tests++; if (tx_start !== 1'b0)  begin fails++; $display("FAIL reset_tx_start: got %b, expected 0", tx_start); end
    tests++; if (tx_data !== 8'h00)  begin fails++; $display("FAIL reset_tx_data: got %h, expected 00", tx_data); end
    tests++; if (grant_id !== 2'd0)  begin fails++; $display("FAIL reset_grant_id: got %0d, expected 0", grant_id); end
    tests++; if (active !== 1'b0)    begin fails++; $display("FAIL reset_active: got %b, expected 0", active); end
    tests++; if (err !== 1'b0)       begin fails++; $display("FAIL reset_err: got %b, expected 0", err); end
    tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL reset_req_ready: got %b, expected 0000", req_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    int s;
    int c;
    busy_len = 4340;
    clear_log();
    set_req(1, 8'hA5, 1'b1, 1'b1);
    wait_starts(1, 50, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_start: got no tx_start, expected 1"); end
    set_req(1, 8'h00, 1'b0, 1'b0);
    s = gcyc(0);
    wait_inactive(6000, c, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_inactive: active still %b, expected 0", active); end
    tests++; if (st_cyc.size() != 1) begin fails++; $display("FAIL single_pulses: got %0d, expected 1", st_cyc.size()); end
    tests++; if (gdat(0) !== 8'hA5) begin fails++; $display("FAIL single_data: got %h, expected a5", gdat(0)); end
    tests++; if (ggnt(0) !== 2'd1) begin fails++; $display("FAIL single_grant: got %0d, expected 1", ggnt(0)); end
    // busy high for 4340 cycles from start+1, gap of 868 once busy is seen low
    tests++; if (c != s + 4340 + 870) begin fails++; $display("FAIL single_active_fall: got cycle %0d, expected %0d", c, s + 4340 + 870); end
    tests++; if (tx_data !== 8'hA5) begin fails++; $display("FAIL single_data_hold: got %h, expected a5", tx_data); end
    tests++; if (err_cyc.size() != 0) begin fails++; $display("FAIL single_err: got %0d pulses, expected 0", err_cyc.size()); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int c;
    logic [1:0] eg;
    logic [7:0] ed;
    apply_reset();
    busy_len = 40;
    clear_log();
    for (int i = 0; i < 4; i++) set_req(i, 8'(8'h10 + i), 1'b1, 1'b1);
    wait_starts(5, 6000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rr_starts: got %0d, expected 5", st_cyc.size()); end
    req_valid = '0;
    wait_inactive(2000, c, ok);
    for (int i = 0; i < 5; i++) begin
      eg = 2'(i % 4);
      ed = 8'(8'h10 + (i % 4));
      tests++; if (ggnt(i) !== eg) begin fails++; $display("FAIL rr_grant[%0d]: got %0d, expected %0d", i, ggnt(i), eg); end
      tests++; if (gdat(i) !== ed) begin fails++; $display("FAIL rr_data[%0d]: got %h, expected %h", i, gdat(i), ed); end
    end
    for (int i = 1; i < 5; i++) begin
      tests++;
      if (gcyc(i) - gcyc(i-1) != 40 + 872) begin
        fails++; $display("FAIL rr_spacing[%0d]: got %0d cycles, expected %0d", i, gcyc(i) - gcyc(i-1), 40 + 872);
      end
    end
  endtask

  task automatic test_lock();
    bit ok;
    int c;
    logic [7:0] bytes [3];
    logic [1:0] eg [4];
    logic [7:0] ed [4];
    int         ex [4];
    bytes = '{8'h01, 8'h02, 8'h03};
    eg = '{2'd2, 2'd2, 2'd2, 2'd0};
    ed = '{8'h01, 8'h02, 8'h03, 8'h77};
    ex = '{0, 43, 43, 912};
    clear_log();
    set_req(0, 8'h77, 1'b1, 1'b1);
    for (int b = 0; b < 3; b++) begin
      set_req(2, bytes[b], (b == 2), 1'b1);
      wait_ready(2, 3000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL lock_ready[%0d]: got %b, expected 1", b, req_ready[2]); end
      tick();
    end
    set_req(2, 8'h00, 1'b0, 1'b0);
    wait_starts(4, 2000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL lock_starts: got %0d, expected 4", st_cyc.size()); end
    set_req(0, 8'h00, 1'b0, 1'b0);
    wait_inactive(2000, c, ok);
    for (int i = 0; i < 4; i++) begin
      tests++; if (ggnt(i) !== eg[i]) begin fails++; $display("FAIL lock_grant[%0d]: got %0d, expected %0d", i, ggnt(i), eg[i]); end
      tests++; if (gdat(i) !== ed[i]) begin fails++; $display("FAIL lock_data[%0d]: got %h, expected %h", i, gdat(i), ed[i]); end
    end
    for (int i = 1; i < 4; i++) begin
      tests++;
      if (gcyc(i) - gcyc(i-1) != ex[i]) begin
        fails++; $display("FAIL lock_spacing[%0d]: got %0d, expected %0d", i, gcyc(i) - gcyc(i-1), ex[i]);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int c;
    int bad_gnt;
    busy_len = 20;
    clear_log();
    set_req(3, 8'hC1, 1'b0, 1'b1);
    wait_ready(3, 3000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stall_ready: got %b, expected 1", req_ready[3]); end
    tick();
    set_req(3, 8'h00, 1'b0, 1'b0);
    set_req(1, 8'h5A, 1'b1, 1'b1);
    bad_gnt = 0;
    repeat (50) begin
      tick();
      if (grant_id !== 2'd3 || active !== 1'b1) bad_gnt++;
    end
    tests++; if (bad_gnt != 0) begin fails++; $display("FAIL stall_grant_held: got %0d bad cycles, expected 0", bad_gnt); end
    tests++; if (st_cyc.size() != 1) begin fails++; $display("FAIL stall_no_start: got %0d starts, expected 1", st_cyc.size()); end
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL stall_in_load: got ready %b, expected 1000", req_ready); end
    c = cyc;
    set_req(3, 8'hC2, 1'b1, 1'b1);
    wait_starts(2, 50, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stall_resume: got %0d starts, expected 2", st_cyc.size()); end
    set_req(3, 8'h00, 1'b0, 1'b0);
    tests++; if (gcyc(1) != c + 1) begin fails++; $display("FAIL stall_latency: got cycle %0d, expected %0d", gcyc(1), c + 1); end
    tests++; if (gdat(1) !== 8'hC2 || ggnt(1) !== 2'd3) begin fails++; $display("FAIL stall_byte2: got %h/%0d, expected c2/3", gdat(1), ggnt(1)); end
    wait_starts(3, 2000, ok);
    set_req(1, 8'h00, 1'b0, 1'b0);
    tests++; if (gdat(2) !== 8'h5A || ggnt(2) !== 2'd1) begin fails++; $display("FAIL stall_next: got %h/%0d, expected 5a/1", gdat(2), ggnt(2)); end
    tests++; if (gcyc(2) - gcyc(1) != 20 + 872) begin fails++; $display("FAIL stall_gap: got %0d, expected %0d", gcyc(2) - gcyc(1), 20 + 872); end
    wait_inactive(2000, c, ok);
  endtask

  task automatic test_timeout();
    bit ok;
    int c;
    int k;
    int s;
    busy_en = 1'b0;
    clear_log();
    set_req(0, 8'h3C, 1'b1, 1'b1);
    wait_starts(1, 50, ok);
    tests++; if (!ok) begin fails++; $display("FAIL timeout_start: got no tx_start, expected 1"); end
    s = gcyc(0);
    set_req(0, 8'h3D, 1'b1, 1'b1);
    wait_starts(2, 1200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL timeout_rearb: got %0d starts, expected 2", st_cyc.size()); end
    set_req(0, 8'h00, 1'b0, 1'b0);
    k = 0;
    while (err_cyc.size() < 2 && k < 40) begin tick(); k++; end
    wait_inactive(2000, c, ok);
    busy_en = 1'b1;
    tests++; if (gerr(0) != s + 16) begin fails++; $display("FAIL timeout_err_cycle: got %0d, expected %0d", gerr(0), s + 16); end
    tests++; if (gcyc(1) != s + 887) begin fails++; $display("FAIL timeout_gap: got start at %0d, expected %0d", gcyc(1), s + 887); end
    tests++; if (ggnt(1) !== 2'd0 || gdat(1) !== 8'h3D) begin fails++; $display("FAIL timeout_next: got %0d/%h, expected 0/3d", ggnt(1), gdat(1)); end
    tests++; if (gerr(1) != gcyc(1) + 16) begin fails++; $display("FAIL timeout_err2: got %0d, expected %0d", gerr(1), gcyc(1) + 16); end
    tests++; if (err_cyc.size() != 2) begin fails++; $display("FAIL timeout_err_count: got %0d, expected 2", err_cyc.size()); end
  endtask

  task automatic test_pair();
    bit ok;
    int c;
    logic [1:0] eg [3];
    logic [7:0] ed [3];
`ifdef UART_TX_SCHED_PRIO0_EN
    eg = '{2'd0, 2'd0, 2'd0};
    ed = '{8'hA0, 8'hA0, 8'hA0};
`else
    eg = '{2'd1, 2'd0, 2'd1};
    ed = '{8'hB1, 8'hA0, 8'hB1};
`endif
    busy_len = 20;
    clear_log();
    set_req(0, 8'hA0, 1'b1, 1'b1);
    set_req(1, 8'hB1, 1'b1, 1'b1);
    wait_starts(3, 4000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL pair_starts: got %0d, expected 3", st_cyc.size()); end
    req_valid = '0;
    wait_inactive(2000, c, ok);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (ggnt(i) !== eg[i] || gdat(i) !== ed[i]) begin
        fails++; $display("FAIL pair_grant[%0d]: got %0d/%h, expected %0d/%h", i, ggnt(i), gdat(i), eg[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int c;
    busy_len = 100;
    clear_log();
    set_req(2, 8'hE2, 1'b0, 1'b1);
    wait_starts(1, 50, ok);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    tests++; if (active !== 1'b0 || tx_start !== 1'b0) begin fails++; $display("FAIL midrst_outputs: got active %b start %b, expected 0 0", active, tx_start); end
    tests++; if (req_ready !== 4'h0 || grant_id !== 2'd0 || tx_data !== 8'h00) begin fails++; $display("FAIL midrst_regs: got ready %b gnt %0d data %h, expected 0000 0 00", req_ready, grant_id, tx_data); end
    rst_n = 1'b1;
    set_req(0, 8'hA7, 1'b1, 1'b1);
    wait_starts(2, 50, ok);
    req_valid = '0;
    tests++; if (ggnt(1) !== 2'd0 || gdat(1) !== 8'hA7) begin fails++; $display("FAIL midrst_rearb: got %0d/%h, expected 0/a7", ggnt(1), gdat(1)); end
    wait_inactive(2000, c, ok);
    tests++; if (!ok) begin fails++; $display("FAIL midrst_inactive: active %b, expected 0", active); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_stall();
    test_timeout();
    test_pair();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
